multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Main control FSM for the multi-cycle MIPS core with cache.
- Sequences one instruction over several clocks: fetch, decode, execute, memory, writeback.
- Drives the datapath muxes and register/PC/IR write enables, and supplies the 2-bit aluOp consumed by the ALU control decoder.
- Stalls in memory-access states until the cache returns memReady.

Parameters:
CNT_W, 32, width of performance counters (used only with PERF_CNT_EN)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
opcode  in  6  instr[31:26] from IR
memReady  in  1  cache access complete this cycle
pcWrite  out  1  unconditional PC write
pcWriteCond  out  1  PC write if ALU zero
iorD  out  1  memory address select: 0=PC, 1=ALUOut
memRead  out  1  cache read request
memWrite  out  1  cache write request
irWrite  out  1  IR load
memToReg  out  1  regfile write data: 1=MDR, 0=ALUOut
regDst  out  1  dest register: 1=rd, 0=rt
regWrite  out  1  regfile write enable
aluSrcA  out  1  0=PC, 1=rs
aluSrcB  out  2  00=rt, 01=const 4, 10=signext imm, 11=signext imm<<2
aluOp  out  2  to ALU control: 00 add, 01 sub, 10 funct, 11 and
pcSource  out  2  00=ALU result, 01=ALUOut, 10=jump target
illegalOp  out  1  one-cycle pulse on unsupported opcode
state  out  4  current state code (debug)

Behaviour:
- Moore FSM. Outputs decode from the state register (plus memReady where noted). Outputs not listed for a state are 0.
- State codes:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - EXEC=6, RWB=7, BRANCH=8, JUMP=9, IMMEX=10, IMMWB=11
- Reset:
  - While reset=1 on an edge, state <= FETCH and opReg <= 0.
  - While reset is high, all outputs are forced to 0, state output excepted.
  - Reset overrides any state, including a stall in progress; the pending cache request is simply dropped.
- FETCH:
  - Outputs: memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=00, pcSource=00.
  - irWrite=pcWrite=memReady.
  - Stay in FETCH while memReady=0; go to DECODE when memReady=1.
- DECODE:
  - Outputs: aluSrcB=11, aluOp=00 (branch target precompute).
  - Latch opcode into internal opReg.
  - Next state by opcode:
    - 100011 (lw) or 101011 (sw) -> MEMADR
    - 000000 (R-type) -> EXEC
    - 000100 (beq) -> BRANCH
    - 000010 (j) -> JUMP
    - 001000 (addi) or 001100 (andi) -> IMMEX
    - anything else -> FETCH, with illegalOp=1 for exactly that cycle
- MEMADR: aluSrcA=1, aluSrcB=10, aluOp=00. Go to MEMRD if opReg=lw, else MEMWR.
- MEMRD: memRead=1, iorD=1. Hold until memReady, then MEMWB.
- MEMWB: regWrite=1, memToReg=1, regDst=0 -> FETCH.
- MEMWR: memWrite=1, iorD=1. Hold until memReady, then FETCH.
- EXEC: aluSrcA=1, aluSrcB=00, aluOp=10 -> RWB.
- RWB: regWrite=1, regDst=1, memToReg=0 -> FETCH.
- BRANCH: aluSrcA=1, aluSrcB=00, aluOp=01, pcWriteCond=1, pcSource=01 -> FETCH.
- JUMP: pcWrite=1, pcSource=10 -> FETCH.
- IMMEX: aluSrcA=1, aluSrcB=10, aluOp=00 for addi, 11 for andi -> IMMWB.
- IMMWB: regWrite=1, regDst=0, memToReg=0 -> FETCH.
- Latency with memReady tied high:
  - lw=5 clocks; sw, R-type, addi, andi=4; beq, j=3.
  - Each cycle memReady=0 in FETCH, MEMRD or MEMWR adds one clock.
- memRead/memWrite stay asserted and iorD stays stable for every stall cycle. No request is ever withdrawn before memReady, except by reset.
- memReady is ignored in every state other than FETCH, MEMRD and MEMWR.
- Unused state codes 12-15 go to FETCH on the next edge, with all outputs 0.

Optional Feature:
PERF_CNT_EN:
- When defined, adds two outputs: instCnt (out, CNT_W) and stallCnt (out, CNT_W). Both clear to 0 on reset.
- instCnt increments by 1 on each edge that moves the FSM into FETCH from a terminal state: MEMWB, MEMWR, RWB, BRANCH, JUMP, IMMWB. Illegal-opcode returns are not counted.
- stallCnt increments by 1 on each edge where (memRead|memWrite)=1 and memReady=0.
- Both counters wrap modulo 2^CNT_W.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset, then release with memReady=1 and opcode=000000 -> state sequence 0,1,6,7,0. RWB cycle shows regWrite=1, regDst=1. EXEC shows aluOp=10.
- lw (100011) with memReady low 3 cycles in MEMRD -> MEMRD held 4 clocks with memRead=1, iorD=1 throughout. MEMWB shows memToReg=1. Total 8 clocks FETCH-to-FETCH; stallCnt=3 if enabled.
- beq (000100) then j (000010), memReady=1 -> BRANCH: pcWriteCond=1, pcSource=01, aluOp=01. JUMP: pcWrite=1, pcSource=10. Each takes 3 clocks; instCnt=2.
- andi (001100) vs addi (001000) -> IMMEX aluOp=11 vs 00, aluSrcB=10. IMMWB regWrite=1, regDst=0.
- opcode=111111 -> DECODE pulses illegalOp for 1 clock, returns to FETCH, instCnt unchanged.
- Assert reset during a MEMWR stall -> next state FETCH, memWrite=0 during reset, counters 0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM of the multi-cycle MIPS core with cache.
// Build option PERF_CNT_EN adds instruction/stall performance counters (instCnt, stallCnt).
module multicycle_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             memReady,
    output logic             pcWrite,
    output logic             pcWriteCond,
    output logic             iorD,
    output logic             memRead,
    output logic             memWrite,
    output logic             irWrite,
    output logic             memToReg,
    output logic             regDst,
    output logic             regWrite,
    output logic             aluSrcA,
    output logic [1:0]       aluSrcB,
    output logic [1:0]       aluOp,
    output logic [1:0]       pcSource,
    output logic             illegalOp,
`ifdef PERF_CNT_EN
    output logic [CNT_W-1:0] instCnt,
    output logic [CNT_W-1:0] stallCnt,
`endif
    output logic [3:0]       state
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IMMEX  = 4'd10,
        S_IMMWB  = 4'd11
    } state_t;

    state_t     cur_state;
    state_t     nxt_state;
    logic [5:0] op_reg;

    // State register; opcode is captured while decoding.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= S_FETCH;
            op_reg    <= '0;
        end else begin
            cur_state <= nxt_state;
            if (cur_state == S_DECODE) op_reg <= opcode;
        end
    end

    assign state = 4'(cur_state);

    // Next-state and control decode.
    always_comb begin
        nxt_state   = S_FETCH;
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        iorD        = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        irWrite     = 1'b0;
        memToReg    = 1'b0;
        regDst      = 1'b0;
        regWrite    = 1'b0;
        aluSrcA     = 1'b0;
        aluSrcB     = 2'b00;
        aluOp       = 2'b00;
        pcSource    = 2'b00;
        illegalOp   = 1'b0;
        case (cur_state)
            S_FETCH: begin
                memRead   = 1'b1;
                aluSrcB   = 2'b01;
                irWrite   = memReady;
                pcWrite   = memReady;
                nxt_state = memReady ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                aluSrcB = 2'b11;
                case (opcode)
                    OP_LW, OP_SW:     nxt_state = S_MEMADR;
                    OP_RTYPE:         nxt_state = S_EXEC;
                    OP_BEQ:           nxt_state = S_BRANCH;
                    OP_J:             nxt_state = S_JUMP;
                    OP_ADDI, OP_ANDI: nxt_state = S_IMMEX;
                    default: begin
                        illegalOp = 1'b1;
                        nxt_state = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                aluSrcA   = 1'b1;
                aluSrcB   = 2'b10;
                nxt_state = (op_reg == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                memRead   = 1'b1;
                iorD      = 1'b1;
                nxt_state = memReady ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                regWrite = 1'b1;
                memToReg = 1'b1;
            end
            S_MEMWR: begin
                memWrite  = 1'b1;
                iorD      = 1'b1;
                nxt_state = memReady ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                aluSrcA   = 1'b1;
                aluOp     = 2'b10;
                nxt_state = S_RWB;
            end
            S_RWB: begin
                regWrite = 1'b1;
                regDst   = 1'b1;
            end
            S_BRANCH: begin
                aluSrcA     = 1'b1;
                aluOp       = 2'b01;
                pcWriteCond = 1'b1;
                pcSource    = 2'b01;
            end
            S_JUMP: begin
                pcWrite  = 1'b1;
                pcSource = 2'b10;
            end
            S_IMMEX: begin
                aluSrcA   = 1'b1;
                aluSrcB   = 2'b10;
                aluOp     = (op_reg == OP_ANDI) ? 2'b11 : 2'b00;
                nxt_state = S_IMMWB;
            end
            S_IMMWB: begin
                regWrite = 1'b1;
            end
            default: nxt_state = S_FETCH;
        endcase
        // Reset silences every control line, dropping any pending cache request.
        if (reset) begin
            pcWrite     = 1'b0;
            pcWriteCond = 1'b0;
            iorD        = 1'b0;
            memRead     = 1'b0;
            memWrite    = 1'b0;
            irWrite     = 1'b0;
            memToReg    = 1'b0;
            regDst      = 1'b0;
            regWrite    = 1'b0;
            aluSrcA     = 1'b0;
            aluSrcB     = 2'b00;
            aluOp       = 2'b00;
            pcSource    = 2'b00;
            illegalOp   = 1'b0;
        end
    end

`ifdef PERF_CNT_EN
    logic inst_done_c;

    // An instruction retires when a terminal state hands control back to FETCH.
    assign inst_done_c = (cur_state == S_MEMWB) || (cur_state == S_RWB) ||
                         (cur_state == S_BRANCH) || (cur_state == S_JUMP) ||
                         (cur_state == S_IMMWB) || ((cur_state == S_MEMWR) && memReady);

    always_ff @(posedge clk) begin
        if (reset) begin
            instCnt  <= '0;
            stallCnt <= '0;
        end else begin
            if (inst_done_c) instCnt <= instCnt + CNT_W'(1);
            if ((memRead || memWrite) && !memReady) stallCnt <= stallCnt + CNT_W'(1);
        end
    end
`else
    // CNT_W only sizes the counters, which are absent in this build.
    logic unused_cnt_w;
    assign unused_cnt_w = (CNT_W == 0);
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed scoreboard bench for multicycle_ctrl.
// Driver queues per-cycle expectations; a negedge monitor pops and checks them.
module tb_multicycle_ctrl;

    localparam int unsigned CNT_W = 32;

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_RWB    = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_JUMP   = 4'd9;
    localparam logic [3:0] S_IMMEX  = 4'd10;
    localparam logic [3:0] S_IMMWB  = 4'd11;

    // {pcWrite,pcWriteCond,iorD,memRead,memWrite,irWrite,memToReg,regDst,regWrite,aluSrcA,aluSrcB,aluOp,pcSource,illegalOp}
    localparam logic [16:0] E_ZERO      = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] E_FETCH_R   = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
    localparam logic [16:0] E_FETCH_S   = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
    localparam logic [16:0] E_DECODE    = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
    localparam logic [16:0] E_ILLEGAL   = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_1;
    localparam logic [16:0] E_MEMADR    = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [16:0] E_MEMRD     = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] E_MEMWB     = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
    localparam logic [16:0] E_MEMWR     = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] E_EXEC      = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
    localparam logic [16:0] E_RWB       = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
    localparam logic [16:0] E_BRANCH    = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
    localparam logic [16:0] E_JUMP      = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;
    localparam logic [16:0] E_IMMEX_ADD = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [16:0] E_IMMEX_AND = 17'b0_0_0_0_0_0_0_0_0_1_10_11_00_0;
    localparam logic [16:0] E_IMMWB     = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       memReady;
    logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
    logic       memToReg, regDst, regWrite, aluSrcA, illegalOp;
    logic [1:0] aluSrcB, aluOp, pcSource;
    logic [3:0] state;
`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] instCnt, stallCnt;
`endif

    multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .memReady(memReady),
        .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD),
        .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite),
        .memToReg(memToReg), .regDst(regDst), .regWrite(regWrite),
        .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
        .pcSource(pcSource), .illegalOp(illegalOp),
`ifdef PERF_CNT_EN
        .instCnt(instCnt), .stallCnt(stallCnt),
`endif
        .state(state)
    );

    always #5 clk = ~clk;

    logic [16:0] ctl;
    assign ctl = {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg,
                  regDst, regWrite, aluSrcA, aluSrcB, aluOp, pcSource, illegalOp};

    typedef struct {
        logic [3:0]  st;
        logic [16:0] ctl;
        int unsigned inst;
        int unsigned stall;
        string       name;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Monitor: compare the cycle's outputs against the oldest queued expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            total++;
            if (state !== e.st) begin
                bad++;
                $display("FAIL %s state: got %0d want %0d", e.name, state, e.st);
            end
            total++;
            if (ctl !== e.ctl) begin
                bad++;
                $display("FAIL %s ctl: got %b want %b", e.name, ctl, e.ctl);
            end
`ifdef PERF_CNT_EN
            total++;
            if (instCnt !== CNT_W'(e.inst)) begin
                bad++;
                $display("FAIL %s instCnt: got %0d want %0d", e.name, instCnt, e.inst);
            end
            total++;
            if (stallCnt !== CNT_W'(e.stall)) begin
                bad++;
                $display("FAIL %s stallCnt: got %0d want %0d", e.name, stallCnt, e.stall);
            end
`endif
        end
    end

    task automatic step(input logic rst, input logic [5:0] op, input logic mr,
                        input logic [3:0] st, input logic [16:0] c,
                        input int unsigned ic, input int unsigned sc, input string nm);
        exp_t e;
        reset    = rst;
        opcode   = op;
        memReady = mr;
        e.st = st; e.ctl = c; e.inst = ic; e.stall = sc; e.name = nm;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; opcode = 6'b0; memReady = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        step(1, 6'b000000, 1, S_FETCH,  E_ZERO,      0, 0, "reset");
        // R-type, memReady ignored in EXEC
        step(0, 6'b000000, 1, S_FETCH,  E_FETCH_R,   0, 0, "r_fetch");
        step(0, 6'b000000, 1, S_DECODE, E_DECODE,    0, 0, "r_decode");
        step(0, 6'b000000, 0, S_EXEC,   E_EXEC,      0, 0, "r_exec");
        step(0, 6'b000000, 1, S_RWB,    E_RWB,       0, 0, "r_rwb");
        // lw with three MEMRD stall cycles
        step(0, 6'b100011, 1, S_FETCH,  E_FETCH_R,   1, 0, "lw_fetch");
        step(0, 6'b100011, 1, S_DECODE, E_DECODE,    1, 0, "lw_decode");
        step(0, 6'b100011, 1, S_MEMADR, E_MEMADR,    1, 0, "lw_memadr");
        step(0, 6'b100011, 0, S_MEMRD,  E_MEMRD,     1, 0, "lw_memrd0");
        step(0, 6'b100011, 0, S_MEMRD,  E_MEMRD,     1, 1, "lw_memrd1");
        step(0, 6'b100011, 0, S_MEMRD,  E_MEMRD,     1, 2, "lw_memrd2");
        step(0, 6'b100011, 1, S_MEMRD,  E_MEMRD,     1, 3, "lw_memrd3");
        step(0, 6'b100011, 1, S_MEMWB,  E_MEMWB,     1, 3, "lw_memwb");
        // beq then j
        step(0, 6'b000100, 1, S_FETCH,  E_FETCH_R,   2, 3, "beq_fetch");
        step(0, 6'b000100, 1, S_DECODE, E_DECODE,    2, 3, "beq_decode");
        step(0, 6'b000100, 0, S_BRANCH, E_BRANCH,    2, 3, "beq_branch");
        step(0, 6'b000010, 1, S_FETCH,  E_FETCH_R,   3, 3, "j_fetch");
        step(0, 6'b000010, 1, S_DECODE, E_DECODE,    3, 3, "j_decode");
        step(0, 6'b000010, 1, S_JUMP,   E_JUMP,      3, 3, "j_jump");
        // andi then addi; opcode input changed in IMMEX to prove the latched copy is used
        step(0, 6'b001100, 1, S_FETCH,  E_FETCH_R,   4, 3, "andi_fetch");
        step(0, 6'b001100, 1, S_DECODE, E_DECODE,    4, 3, "andi_decode");
        step(0, 6'b001000, 1, S_IMMEX,  E_IMMEX_AND, 4, 3, "andi_immex");
        step(0, 6'b001100, 1, S_IMMWB,  E_IMMWB,     4, 3, "andi_immwb");
        step(0, 6'b001000, 1, S_FETCH,  E_FETCH_R,   5, 3, "addi_fetch");
        step(0, 6'b001000, 1, S_DECODE, E_DECODE,    5, 3, "addi_decode");
        step(0, 6'b001100, 1, S_IMMEX,  E_IMMEX_ADD, 5, 3, "addi_immex");
        step(0, 6'b001000, 1, S_IMMWB,  E_IMMWB,     5, 3, "addi_immwb");
        // fetch stall, then illegal opcode
        step(0, 6'b111111, 0, S_FETCH,  E_FETCH_S,   6, 3, "ill_fetch_stall");
        step(0, 6'b111111, 1, S_FETCH,  E_FETCH_R,   6, 4, "ill_fetch");
        step(0, 6'b111111, 1, S_DECODE, E_ILLEGAL,   6, 4, "ill_decode");
        // sw with two MEMWR stalls; opcode input says lw in MEMADR
        step(0, 6'b101011, 1, S_FETCH,  E_FETCH_R,   6, 4, "sw_fetch");
        step(0, 6'b101011, 1, S_DECODE, E_DECODE,    6, 4, "sw_decode");
        step(0, 6'b100011, 1, S_MEMADR, E_MEMADR,    6, 4, "sw_memadr");
        step(0, 6'b101011, 0, S_MEMWR,  E_MEMWR,     6, 4, "sw_memwr0");
        step(0, 6'b101011, 0, S_MEMWR,  E_MEMWR,     6, 5, "sw_memwr1");
        step(0, 6'b101011, 1, S_MEMWR,  E_MEMWR,     6, 6, "sw_memwr2");
        // sw interrupted by reset during a MEMWR stall
        step(0, 6'b101011, 1, S_FETCH,  E_FETCH_R,   7, 6, "rsw_fetch");
        step(0, 6'b101011, 1, S_DECODE, E_DECODE,    7, 6, "rsw_decode");
        step(0, 6'b101011, 1, S_MEMADR, E_MEMADR,    7, 6, "rsw_memadr");
        step(0, 6'b101011, 0, S_MEMWR,  E_MEMWR,     7, 6, "rsw_memwr");
        step(1, 6'b101011, 0, S_MEMWR,  E_ZERO,      7, 7, "rsw_reset_hi");
        step(1, 6'b101011, 0, S_FETCH,  E_ZERO,      0, 0, "rsw_reset_fetch");
        step(0, 6'b000000, 1, S_FETCH,  E_FETCH_R,   0, 0, "post_reset_fetch");
        @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
